// File: rtl/fifo_rr_arbiter.sv
// Round-robin drain of NUM_FIFOS input FIFOs into one downstream FIFO, with optional
// per-channel bursts, back-pressure via out_almost_full, and a two-stage data pipeline.
module fifo_rr_arbiter #(
  parameter int NUM_FIFOS      = 4,
  parameter int FIFO_WORD_SIZE = 10,
  parameter int BURST_LEN      = 1,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                enable,
  input  logic [NUM_FIFOS-1:0]                fifo_empty,
  input  logic [NUM_FIFOS*FIFO_WORD_SIZE-1:0] fifo_data,
  input  logic                                out_almost_full,
  output logic [NUM_FIFOS-1:0]                fifo_pop,
  output logic                                out_push,
  output logic [FIFO_WORD_SIZE-1:0]           out_data,
  output logic [$clog2(NUM_FIFOS)-1:0]        grant,
  output logic                                idle,
  output logic [CNT_WIDTH-1:0]                words_sent
);

  localparam int IDX_W = $clog2(NUM_FIFOS);
  localparam int CW    = $clog2(BURST_LEN + 1);
  localparam logic [IDX_W-1:0] LAST_RST  = IDX_W'(NUM_FIFOS - 1);
  localparam logic [CW-1:0]    BURST_MAX = CW'(BURST_LEN);

  typedef enum logic {ARB, HOLD} state_t;

  state_t                    state, state_n;
  logic [CW-1:0]             burst_cnt, burst_n;
  logic [IDX_W-1:0]          last;
  logic                      pop_any;
  logic [IDX_W-1:0]          pop_idx;
  logic                      pop_d;
  logic [IDX_W-1:0]          sel_d;
  logic [NUM_FIFOS-1:0]      eligible;
  logic                      stall, issue_ok;
  logic [IDX_W-1:0]          rr_base, rr_idx, cand;
  logic                      rr_found;
  logic [FIFO_WORD_SIZE-1:0] fifo_word [NUM_FIFOS];

  assign eligible = ~fifo_empty;
  assign stall    = !enable || out_almost_full;
  assign issue_ok = !reset && !stall && (|eligible);

  // A fresh burst scans from the channel after the last grant; once a burst has run in
  // HOLD the scan starts after the current grant, which is the same channel.
  assign rr_base = (state == HOLD) ? grant : last;

  always_comb begin
    for (int i = 0; i < NUM_FIFOS; i++) begin
      fifo_word[i] = fifo_data[i*FIFO_WORD_SIZE +: FIFO_WORD_SIZE];
    end
  end

  // First eligible index after rr_base; rr_base itself is checked last, so a lone
  // eligible channel is re-granted every cycle.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = '0;
    for (int k = 1; k <= NUM_FIFOS; k++) begin
      cand = IDX_W'((int'(rr_base) + k) % NUM_FIFOS);
      if (!rr_found && eligible[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_n = state;
    burst_n = burst_cnt;
    pop_any = 1'b0;
    pop_idx = grant;
    if (issue_ok) begin
      if (state == HOLD && !fifo_empty[grant] && burst_cnt < BURST_MAX) begin
        pop_any = 1'b1;
        pop_idx = grant;
        burst_n = burst_cnt + CW'(1);
      end else begin
        pop_any = rr_found;
        pop_idx = rr_idx;
        burst_n = CW'(1);
        state_n = (BURST_LEN > 1) ? HOLD : ARB;
      end
    end else if (!stall) begin
      state_n = ARB;
    end
  end

  always_comb begin
    fifo_pop = '0;
    if (pop_any) fifo_pop[pop_idx] = 1'b1;
  end

  assign idle = !pop_any && !pop_d && !out_push && (&fifo_empty);

  // NOTE: reset is sampled on the clock edge, and all state updates are non-blocking so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ARB;
      burst_cnt  <= '0;
      grant      <= '0;
      last       <= LAST_RST;
      pop_d      <= 1'b0;
      sel_d      <= '0;
      out_push   <= 1'b0;
      out_data   <= '0;
      words_sent <= '0;
    end else begin
      state     <= state_n;
      burst_cnt <= burst_n;
      if (pop_any) begin
        grant <= pop_idx;
        last  <= pop_idx;
      end
      pop_d    <= pop_any;
      sel_d    <= pop_idx;
      out_push <= pop_d;
      // FIFO read data is valid the cycle after its pop, when pop_d is set.
      if (pop_d) out_data <= fifo_word[sel_d];
      if (out_push) words_sent <= words_sent + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Directed bench: pure round-robin instance (a) and BURST_LEN=2 instance (b), each fed
// by behavioural FIFOs with registered empty flags and next-cycle read data.
module tb_fifo_rr_arbiter;

  localparam int N = 4;
  localparam int W = 10;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             en_a, af_a, en_b, af_b;
  logic [N-1:0]     ea = '1, eb = '1;
  logic [N-1:0]     pop_a, pop_b;
  logic [W-1:0]     dw_a [N], dw_b [N];
  logic [N*W-1:0]   fd_a, fd_b;
  logic             push_a, push_b, idle_a, idle_b;
  logic [W-1:0]     od_a, od_b;
  logic [1:0]       grant_a, grant_b;
  logic [15:0]      ws_a, ws_b;

  logic [W-1:0]     qa [N][$];
  logic [W-1:0]     qb [N][$];
  int               pops_a[$], popc_a[$], pushc_a[$];
  int               pops_b[$], popc_b[$], pushc_b[$];
  logic [W-1:0]     pushd_a[$], pushd_b[$];

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int bad_pop_a = 0, bad_pop_b = 0, multi_hot = 0;
  int mon_ia, mon_ib;

  int          bexp_idx [4] = '{1, 1, 2, 1};
  logic [W-1:0] bexp_dat [4] = '{10'h300, 10'h301, 10'h320, 10'h302};

  assign fd_a = {dw_a[3], dw_a[2], dw_a[1], dw_a[0]};
  assign fd_b = {dw_b[3], dw_b[2], dw_b[1], dw_b[0]};

  always #5 clk = ~clk;

  fifo_rr_arbiter #(.NUM_FIFOS(N), .FIFO_WORD_SIZE(W), .BURST_LEN(1), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .enable(en_a), .fifo_empty(ea), .fifo_data(fd_a),
    .out_almost_full(af_a), .fifo_pop(pop_a), .out_push(push_a), .out_data(od_a),
    .grant(grant_a), .idle(idle_a), .words_sent(ws_a)
  );

  fifo_rr_arbiter #(.NUM_FIFOS(N), .FIFO_WORD_SIZE(W), .BURST_LEN(2), .CNT_WIDTH(16)) dut_b (
    .clk(clk), .reset(reset), .enable(en_b), .fifo_empty(eb), .fifo_data(fd_b),
    .out_almost_full(af_b), .fifo_pop(pop_b), .out_push(push_b), .out_data(od_b),
    .grant(grant_b), .idle(idle_b), .words_sent(ws_b)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Input FIFO models: pop sampled on the edge, data and empty flag update together.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (pop_a[i]) begin
        if (qa[i].size() > 0) dw_a[i] <= qa[i].pop_front();
        else bad_pop_a <= bad_pop_a + 1;
      end
      ea[i] <= (qa[i].size() == 0);
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (pop_b[i]) begin
        if (qb[i].size() > 0) dw_b[i] <= qb[i].pop_front();
        else bad_pop_b <= bad_pop_b + 1;
      end
      eb[i] <= (qb[i].size() == 0);
    end
  end

  always @(negedge clk) begin
    mon_ia = 0;
    mon_ib = 0;
    for (int i = 0; i < N; i++) begin
      if (pop_a[i]) mon_ia = i;
      if (pop_b[i]) mon_ib = i;
    end
    if ($countones(pop_a) > 1 || $countones(pop_b) > 1) multi_hot = multi_hot + 1;
    if (|pop_a) begin pops_a.push_back(mon_ia); popc_a.push_back(cyc); end
    if (|pop_b) begin pops_b.push_back(mon_ib); popc_b.push_back(cyc); end
    if (push_a) begin pushd_a.push_back(od_a); pushc_a.push_back(cyc); end
    if (push_b) begin pushd_b.push_back(od_b); pushc_b.push_back(cyc); end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    pops_a.delete(); popc_a.delete(); pushc_a.delete(); pushd_a.delete();
    pops_b.delete(); popc_b.delete(); pushc_b.delete(); pushd_b.delete();
  endtask

  task automatic load(input bit use_b, input int f, input int n, input int base);
    for (int k = 0; k < n; k++) begin
      if (use_b) qb[f].push_back(W'(base + k));
      else       qa[f].push_back(W'(base + k));
    end
  endtask

  task automatic wait_sent(input bit use_b, input int target, input int budget, input string tag);
    int k;
    k = 0;
    while (k < budget && (use_b ? ws_b : ws_a) != 16'(target)) begin
      @(negedge clk); #1; k++;
    end
    check(tag, use_b ? ws_b : ws_a, target);
  endtask

  task automatic wait_pops(input bit use_b, input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (k < budget && (use_b ? pops_b.size() : pops_a.size()) < n) begin
      @(negedge clk); #1; k++;
    end
    check(tag, (use_b ? pops_b.size() : pops_a.size()) >= n, 1);
  endtask

  task automatic wait_pushes(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (k < budget && pushd_a.size() < n) begin
      @(negedge clk); #1; k++;
    end
    check(tag, pushd_a.size() >= n, 1);
  endtask

  initial begin
    int raise_cyc;
    int n_after;
    en_a = 1'b1; af_a = 1'b0; en_b = 1'b1; af_b = 1'b0;

    // Reset values with all FIFOs empty
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pop", pop_a, 0);
    check("rst_push", push_a, 0);
    check("rst_data", od_a, 0);
    check("rst_grant", grant_a, 0);
    check("rst_idle", idle_a, 1);
    check("rst_ws", ws_a, 0);
    check("rst_b_pop", pop_b, 0);
    tick();
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("empty_no_pop", pops_a.size(), 0);
    check("empty_idle", idle_a, 1);
    check("empty_ws", ws_a, 0);

    // Pure round robin: two words in each FIFO
    tick();
    clear_logs();
    for (int f = 0; f < N; f++) load(0, f, 2, 'h100 + f*16);
    wait_sent(0, 8, 40, "rr_sent");
    check("rr_npops", pops_a.size(), 8);
    check("rr_npush", pushd_a.size(), 8);
    for (int j = 0; j < 8 && j < pops_a.size() && j < pushd_a.size(); j++) begin
      check("rr_order", pops_a[j], j % 4);
      check("rr_data", pushd_a[j], 'h100 + (j % 4)*16 + j/4);
      check("rr_push_cyc", pushc_a[j], popc_a[0] + 2 + j);
    end
    repeat (3) @(negedge clk);
    check("rr_idle", idle_a, 1);

    // Single eligible FIFO streams without bubbles
    tick();
    clear_logs();
    load(0, 3, 4, 'h1c0);
    wait_sent(0, 12, 30, "solo_sent");
    check("solo_npops", pops_a.size(), 4);
    for (int j = 0; j < 4 && j < pops_a.size() && j < pushd_a.size(); j++) begin
      check("solo_idx", pops_a[j], 3);
      check("solo_data", pushd_a[j], 'h1c0 + j);
      check("solo_push_cyc", pushc_a[j], popc_a[0] + 2 + j);
    end
    check("solo_grant", grant_a, 3);

    // Back-pressure mid-stream
    tick();
    clear_logs();
    for (int f = 0; f < N; f++) load(0, f, 3, 'h200 + f*16);
    wait_pops(0, 3, 30, "bp_start");
    tick();
    af_a = 1'b1;
    raise_cyc = cyc;
    repeat (6) @(negedge clk);
    check("bp_no_pop", pops_a.size(), 3);
    check("bp_inflight_done", pushd_a.size(), 3);
    n_after = 0;
    foreach (pushc_a[j]) if (pushc_a[j] >= raise_cyc) n_after++;
    check("bp_late_push", n_after, 2);
    tick();
    af_a = 1'b0;
    wait_pops(0, 4, 10, "bp_resume");
    check("bp_resume_idx", pops_a[3], 3);
    wait_sent(0, 24, 60, "bp_sent");
    for (int j = 0; j < 12 && j < pops_a.size() && j < pushd_a.size(); j++) begin
      check("bp_order", pops_a[j], j % 4);
      check("bp_data", pushd_a[j], 'h200 + (j % 4)*16 + j/4);
    end

    // Burst of two on instance b
    tick();
    clear_logs();
    load(1, 1, 3, 'h300);
    load(1, 2, 1, 'h320);
    wait_sent(1, 4, 30, "burst_sent");
    check("burst_npops", pops_b.size(), 4);
    for (int j = 0; j < 4 && j < pops_b.size() && j < pushd_b.size(); j++) begin
      check("burst_order", pops_b[j], bexp_idx[j]);
      check("burst_data", pushd_b[j], bexp_dat[j]);
      check("burst_push_cyc", pushc_b[j], popc_b[0] + 2 + j);
    end

    // Reset with words in flight
    tick();
    clear_logs();
    for (int f = 0; f < N; f++) load(0, f, 4, 'h040 + f*16);
    wait_pops(0, 2, 30, "rst_stream");
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    en_a  = 1'b0;
    clear_logs();
    @(negedge clk);
    check("mid_rst_push", push_a, 0);
    check("mid_rst_grant", grant_a, 0);
    check("mid_rst_ws", ws_a, 0);
    check("mid_rst_data", od_a, 0);
    check("mid_rst_pop", pop_a, 0);
    check("mid_rst_idle", idle_a, 0);
    repeat (3) @(negedge clk);
    check("dis_no_pop", pops_a.size(), 0);
    check("dis_no_push", pushd_a.size(), 0);
    tick();
    en_a = 1'b1;
    wait_pops(0, 1, 10, "post_rst_pop");
    check("post_rst_idx", pops_a[0], 0);
    wait_pushes(1, 10, "post_rst_push");
    check("post_rst_lat", pushc_a[0], popc_a[0] + 2);
    check("post_rst_data", pushd_a[0], 'h041);

    repeat (20) @(negedge clk);
    check("no_empty_pop_a", bad_pop_a, 0);
    check("no_empty_pop_b", bad_pop_b, 0);
    check("one_hot", multi_hot, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
